// File: rtl/key_event_unit_pkg.sv
// Shared keycode constants, FSM state type and key classification for the
// keyboard front-end of the gravity simulator.
package gravsim_key_pkg;

  localparam logic [7:0] KEYCODE_SPACE     = 8'd44;
  localparam logic [7:0] KEYCODE_W         = 8'd26;
  localparam logic [7:0] KEYCODE_S         = 8'd22;
  localparam logic [7:0] KEYCODE_A         = 8'd4;
  localparam logic [7:0] KEYCODE_D         = 8'd7;
  localparam logic [7:0] KEYCODE_PAGE_UP   = 8'd75;
  localparam logic [7:0] KEYCODE_PAGE_DOWN = 8'd78;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    REPEAT
  } key_state_t;

  // Pan and zoom keys auto-repeat; SPACE and unknown codes never do.
  function automatic logic is_repeatable(input logic [7:0] code);
    logic rep;
    rep = 1'b0;
    case (code)
      KEYCODE_W, KEYCODE_S, KEYCODE_A, KEYCODE_D,
      KEYCODE_PAGE_UP, KEYCODE_PAGE_DOWN: rep = 1'b1;
      default:                            rep = 1'b0;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/key_event_unit_frame_tick_gen.sv
// One-cycle frame tick on each rising edge of VGA_VS; shared with the
// Avalon interface so both agree on frame boundaries.
module frame_tick_gen (
  input  logic CLK,
  input  logic RESET,
  input  logic VGA_VS,
  output logic tick
);

  logic vs_d;

  always_ff @(posedge CLK) begin
    if (RESET) vs_d <= 1'b0;
    else       vs_d <= VGA_VS;
  end

  assign tick = VGA_VS & ~vs_d;

endmodule

// File: rtl/key_event_unit.sv
// Debounces the raw keycode and turns accepted keys into one-cycle command
// pulses, with frame-rate auto-repeat for pan/zoom and a pause toggle.
module key_event_unit
  import gravsim_key_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_RATE   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] keycode,
  input  logic       VGA_VS,
  output logic       paused,
  output logic       pause_toggle,
  output logic       step_up,
  output logic       step_down,
  output logic       step_left,
  output logic       step_right,
  output logic       step_in,
  output logic       step_out,
  output logic [7:0] held_code
);

  localparam int STAB_W    = $clog2(STABLE_CYCLES + 1);
  localparam int FRAME_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

  localparam logic [STAB_W-1:0]  STAB_LIMIT  = STAB_W'(STABLE_CYCLES);
  localparam logic [FRAME_W-1:0] DELAY_LIMIT = FRAME_W'(REPEAT_DELAY);
  localparam logic [FRAME_W-1:0] RATE_LIMIT  = FRAME_W'(REPEAT_RATE);
  localparam logic [FRAME_W-1:0] FRAME_SAT   = FRAME_W'(FRAME_MAX);

  key_state_t         state_reg, state_next;
  logic [7:0]         held_next;
  logic [STAB_W-1:0]  stab_cnt_reg, stab_cnt_next;
  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next, frame_inc;
  logic               fire_next;
  logic               tick;

  frame_tick_gen u_frame_tick_gen (
    .CLK    (CLK),
    .RESET  (RESET),
    .VGA_VS (VGA_VS),
    .tick   (tick)
  );

  always_comb begin
    state_next     = state_reg;
    held_next      = held_code;
    stab_cnt_next  = stab_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    fire_next      = 1'b0;
    frame_inc      = (frame_cnt_reg == FRAME_SAT) ? frame_cnt_reg
                                                  : frame_cnt_reg + FRAME_W'(1);

    case (state_reg)
      IDLE: begin
        if (keycode != 8'd0) begin
          held_next     = keycode;
          stab_cnt_next = STAB_W'(1);
          state_next    = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (keycode != held_code) begin
          if (keycode == 8'd0) begin
            held_next  = 8'd0;
            state_next = IDLE;
          end else begin
            held_next     = keycode;
            stab_cnt_next = STAB_W'(1);
          end
        end else if (stab_cnt_reg == STAB_LIMIT) begin
          state_next     = HELD;
          frame_cnt_next = '0;
          fire_next      = 1'b1;
        end else begin
          stab_cnt_next = stab_cnt_reg + STAB_W'(1);
        end
      end

      HELD, REPEAT: begin
        // A code change wins over a coincident tick, so the old key goes silent.
        if (keycode != held_code) begin
          if (keycode == 8'd0) begin
            held_next  = 8'd0;
            state_next = IDLE;
          end else begin
            held_next     = keycode;
            stab_cnt_next = STAB_W'(1);
            state_next    = DEBOUNCE;
          end
        end else if (tick) begin
          if (state_reg == HELD) begin
            if (is_repeatable(held_code) && frame_inc == DELAY_LIMIT) begin
              fire_next      = 1'b1;
              frame_cnt_next = '0;
              state_next     = REPEAT;
            end else begin
              frame_cnt_next = frame_inc;
            end
          end else if (frame_inc == RATE_LIMIT) begin
            fire_next      = 1'b1;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_inc;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      held_code     <= 8'd0;
      stab_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      paused        <= 1'b1;
      pause_toggle  <= 1'b0;
      step_up       <= 1'b0;
      step_down     <= 1'b0;
      step_left     <= 1'b0;
      step_right    <= 1'b0;
      step_in       <= 1'b0;
      step_out      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      held_code     <= held_next;
      stab_cnt_reg  <= stab_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      // Pulses always belong to the code being tracked before this edge.
      paused        <= paused ^ (fire_next && held_code == KEYCODE_SPACE);
      pause_toggle  <= fire_next && (held_code == KEYCODE_SPACE);
      step_up       <= fire_next && (held_code == KEYCODE_W);
      step_down     <= fire_next && (held_code == KEYCODE_S);
      step_left     <= fire_next && (held_code == KEYCODE_A);
      step_right    <= fire_next && (held_code == KEYCODE_D);
      step_in       <= fire_next && (held_code == KEYCODE_PAGE_UP);
      step_out      <= fire_next && (held_code == KEYCODE_PAGE_DOWN);
    end
  end

endmodule

// File: tb/tb_key_event_unit.sv
// Scoreboard bench for key_event_unit: a run-length/tick-count reference
// model predicts every pulse; a negedge monitor pops and compares.
module tb_key_event_unit;

  localparam int SC = 4;
  localparam int RD = 3;
  localparam int RR = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       VGA_VS = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic       paused, pause_toggle;
  logic       step_up, step_down, step_left, step_right, step_in, step_out;
  logic [7:0] held_code;

  key_event_unit #(
    .STABLE_CYCLES (SC),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .keycode      (keycode),
    .VGA_VS       (VGA_VS),
    .paused       (paused),
    .pause_toggle (pause_toggle),
    .step_up      (step_up),
    .step_down    (step_down),
    .step_left    (step_left),
    .step_right   (step_right),
    .step_in      (step_in),
    .step_out     (step_out),
    .held_code    (held_code)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      repeat (10) @(posedge CLK);
      #1 VGA_VS = ~VGA_VS;
    end
  end

  typedef struct {
    int         cyc;
    logic [6:0] mask;
    logic       paused;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulse_cnt [7];

  // bit 6 pause_toggle, 5 up, 4 down, 3 left, 2 right, 1 in, 0 out
  function automatic logic [6:0] code_mask(input logic [7:0] c);
    case (c)
      8'd44:   return 7'b1000000;
      8'd26:   return 7'b0100000;
      8'd22:   return 7'b0010000;
      8'd4:    return 7'b0001000;
      8'd7:    return 7'b0000100;
      8'd75:   return 7'b0000010;
      8'd78:   return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: a key is accepted once it has been sampled on SC+1
  // consecutive edges; repeats land on tick RD, RD+RR, ... after acceptance.
  logic [7:0] m_code = 8'd0;
  int         m_run = 0;
  int         m_ticks = 0;
  bit         m_accepted = 0;
  logic       m_paused = 1'b1;
  logic       m_prev_vs = 1'b0;
  logic       m_tick;
  logic [7:0] last_code = 8'd0;
  logic       last_rst = 1'b1;

  task automatic emit(input logic [7:0] c);
    exp_t e;
    if (c == 8'd44) m_paused = ~m_paused;
    e.cyc = cyc;
    e.mask = code_mask(c);
    e.paused = m_paused;
    if (e.mask != 7'd0) exp_q.push_back(e);
  endtask

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (RESET) begin
      m_code = 8'd0; m_run = 0; m_accepted = 0; m_paused = 1'b1; m_prev_vs = 1'b0;
    end else begin
      m_tick = VGA_VS && !m_prev_vs;
      m_prev_vs = VGA_VS;
      if (keycode == 8'd0) begin
        m_code = 8'd0; m_run = 0; m_accepted = 0;
      end else if (keycode != m_code) begin
        m_code = keycode; m_run = 1; m_accepted = 0;
      end else begin
        m_run = m_run + 1;
        if (!m_accepted && m_run == SC + 1) begin
          m_accepted = 1; m_ticks = 0;
          emit(m_code);
        end else if (m_accepted && m_tick) begin
          m_ticks = m_ticks + 1;
          if (code_mask(m_code) != 7'd0 && m_code != 8'd44 &&
              (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RR == 0)))
            emit(m_code);
        end
      end
    end
    last_code = keycode;
    last_rst = RESET;
  end

  always @(negedge CLK) begin
    logic [6:0] mask;
    exp_t e;
    mask = {pause_toggle, step_up, step_down, step_left, step_right, step_in, step_out};
    for (int i = 0; i < 7; i++) if (mask[i]) pulse_cnt[i]++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      tests++; fails++;
      $display("FAIL missing_pulse cyc=%0d got none, required mask=%b", e.cyc, e.mask);
    end
    if (mask != 7'd0) begin
      tests++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got mask=%b, required none", cyc, mask);
      end else begin
        e = exp_q.pop_front();
        if (e.mask != mask) begin
          fails++;
          $display("FAIL pulse_mask cyc=%0d got %b, required %b", cyc, mask, e.mask);
        end
      end
    end
    tests++;
    if (paused !== m_paused) begin
      fails++;
      $display("FAIL paused cyc=%0d got %b, required %b", cyc, paused, m_paused);
    end
    if (last_rst) begin
      tests++;
      if (mask !== 7'd0 || held_code !== 8'd0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d got mask=%b held=%0d, required 0/0", cyc, mask, held_code);
      end
    end else if (last_code != 8'd0) begin
      tests++;
      if (held_code !== last_code) begin
        fails++;
        $display("FAIL held_code cyc=%0d got %0d, required %0d", cyc, held_code, last_code);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_key(input logic [7:0] k, input int n);
    keycode = k;
    cycles(n);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    int c0, c1;
    bit found;
    logic [7:0] codes [9];
    codes = '{8'd0, 8'd26, 8'd22, 8'd4, 8'd7, 8'd75, 8'd78, 8'd44, 8'd99};

    cycles(3);
    RESET = 1'b0;
    cycles(6);

    // Debounce, then a glitch that restarts it with a different key
    c0 = pulse_cnt[5];
    set_key(8'd26, 20);
    set_key(8'd0, 5);
    check("step_up_once", pulse_cnt[5] - c0, 1);
    c0 = pulse_cnt[5]; c1 = pulse_cnt[4];
    set_key(8'd26, 2);
    set_key(8'd22, 20);
    set_key(8'd0, 5);
    check("glitch_no_up", pulse_cnt[5] - c0, 0);
    check("glitch_down", pulse_cnt[4] - c1, 1);

    // Reset mid-debounce
    c0 = pulse_cnt[5];
    keycode = 8'd26; cycles(2);
    RESET = 1'b1; cycles(2);
    RESET = 1'b0; keycode = 8'd0; cycles(8);
    check("reset_abort", pulse_cnt[5] - c0, 0);

    // Auto-repeat over ten frames
    c0 = pulse_cnt[2];
    set_key(8'd7, 200);
    set_key(8'd0, 40);
    check("right_repeat", pulse_cnt[2] - c0, 5);

    // Pause toggle, no repeat
    c0 = pulse_cnt[6];
    set_key(8'd44, 200);
    set_key(8'd0, 10);
    check("pause_once", pulse_cnt[6] - c0, 1);
    check("paused_low", paused, 0);
    set_key(8'd44, 30);
    set_key(8'd0, 10);
    check("paused_high", paused, 1);

    // Switch on a tick that would have repeated PAGE UP
    set_key(8'd75, 100);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge VGA_VS);
      if (m_accepted && (m_ticks + 1) > RD && ((m_ticks + 1 - RD) % RR) == 0) found = 1;
    end
    keycode = 8'd78;
    check("collision_setup", found, 1);
    c0 = pulse_cnt[1]; c1 = pulse_cnt[0];
    cycles(30);
    check("collision_no_in", pulse_cnt[1] - c0, 0);
    check("collision_out", pulse_cnt[0] - c1, 1);
    set_key(8'd0, 10);

    // Unknown code, then direct change to A
    c0 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] +
         pulse_cnt[4] + pulse_cnt[5] + pulse_cnt[6];
    set_key(8'd99, 100);
    check("unknown_held", held_code, 99);
    c1 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] +
         pulse_cnt[4] + pulse_cnt[5] + pulse_cnt[6];
    check("unknown_silent", c1 - c0, 0);
    c0 = pulse_cnt[3];
    set_key(8'd4, 20);
    check("left_after_unknown", pulse_cnt[3] - c0, 1);
    set_key(8'd0, 10);

    // Randomised segments, with occasional reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        RESET = 1'b1;
        cycles($urandom_range(1, 2));
        RESET = 1'b0;
      end
      set_key(codes[$urandom_range(0, 8)], $urandom_range(1, 40));
    end

    set_key(8'd0, 10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
